clk_divider_multi: RTL

- Multi-channel, runtime-programmable clock divider. Successor to the fixed-constant single-channel divider.
- Each of NUM_CH channels produces a 50%-duty divided clock whose half-period (in clk cycles) is written over a simple config port. Each channel also has a per-channel enable and a one-cycle rising-edge tick.
- Divisor updates are glitch-free: a new value takes effect only at a half-period boundary. Sits between the board clock and slow peripherals/counters that need several independent rates.

---
 rtl/clkdiv_pkg.sv | 17 +
 rtl/clk_div_chan.sv | 81 ++++++++
 rtl/clk_divider_multi.sv | 71 +++++++
 3 files changed

// File: rtl/clkdiv_pkg.sv
// Shared definitions for the multi-channel clock divider.
//   DefaultHalf : reset half-period loaded into every channel.
//   ch_width()  : channel-index width, max(1, ceil(log2(n))).
package clkdiv_pkg;

  localparam int unsigned DefaultHalf = 3;

  function automatic int unsigned ch_width(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: 50%-duty divided clock with a programmable half-period.
// Ports:
//   i_clk, i_rst   : system clock, async active-high reset
//   i_en           : run enable; low forces count/clk_div/tick to 0
//   i_wr, i_half   : validated config write for this channel and its value
//   o_clk_div      : registered divided clock
//   o_tick         : one-cycle pulse in the cycle o_clk_div first reads 1
//   o_pend         : a written half-period is waiting for the next boundary
module clk_div_chan
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DEFAULT_HALF = DefaultHalf
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_half,
  output logic             o_clk_div,
  output logic             o_tick,
  output logic             o_pend
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_active;
  logic [CNT_W-1:0] r_shadow;
  logic             r_div;
  logic             r_tick;
  logic             r_pend;
  logic             w_term;
  logic             w_boundary;

  assign w_term = (r_count == r_active - CNT_W'(1));
  // A disabled channel sits at count 0, so it is always at a half-period boundary.
  assign w_boundary = !i_en || w_term;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count  <= '0;
      r_active <= CNT_W'(DEFAULT_HALF);
      r_shadow <= CNT_W'(DEFAULT_HALF);
      r_div    <= 1'b0;
      r_tick   <= 1'b0;
      r_pend   <= 1'b0;
    end else begin
      if (!i_en) begin
        r_count <= '0;
        r_div   <= 1'b0;
        r_tick  <= 1'b0;
      end else if (w_term) begin
        r_count <= '0;
        r_div   <= ~r_div;
        r_tick  <= ~r_div;  // tick only on the 0->1 toggle
      end else begin
        r_count <= r_count + CNT_W'(1);
        r_tick  <= 1'b0;
      end

      // New half-periods only ever take effect at count 0, so the count can
      // never be stranded above a shrunken half-period.
      if (i_wr) begin
        if (w_boundary) begin
          r_active <= i_half;
          r_pend   <= 1'b0;
        end else begin
          r_shadow <= i_half;
          r_pend   <= 1'b1;
        end
      end else if (r_pend && w_boundary) begin
        r_active <= r_shadow;
        r_pend   <= 1'b0;
      end
    end
  end

  assign o_clk_div = r_div;
  assign o_tick    = r_tick;
  assign o_pend    = r_pend;

endmodule

// File: rtl/clk_divider_multi.sv
// Multi-channel runtime-programmable clock divider.
// Ports:
//   i_clk, i_rst : system clock, async active-high reset
//   i_en         : per-channel run enable
//   i_cfg_we     : one-cycle config write strobe
//   i_cfg_ch     : target channel of the write
//   i_cfg_half   : new half-period (clk cycles, non-zero)
//   o_cfg_err    : one-cycle pulse after a rejected write (bad channel or zero)
//   o_clk_div    : divided clocks, registered
//   o_tick       : one-cycle pulse when o_clk_div[i] rises
//   o_pend       : channel holds a written value not yet applied
module clk_divider_multi
  import clkdiv_pkg::*;
#(
  parameter int unsigned  NUM_CH       = 4,
  parameter int unsigned  CNT_W        = 16,
  parameter int unsigned  DEFAULT_HALF = DefaultHalf,
  localparam int unsigned CH_W         = ch_width(NUM_CH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_en,
  input  logic              i_cfg_we,
  input  logic [CH_W-1:0]   i_cfg_ch,
  input  logic [CNT_W-1:0]  i_cfg_half,
  output logic              o_cfg_err,
  output logic [NUM_CH-1:0] o_clk_div,
  output logic [NUM_CH-1:0] o_tick,
  output logic [NUM_CH-1:0] o_pend
);

  logic              w_ch_ok;
  logic              w_half_ok;
  logic              w_cfg_ok;
  logic [NUM_CH-1:0] w_wr;
  logic              r_cfg_err;

  // Extra MSB so a NUM_CH that is an exact power of two still compares correctly.
  assign w_ch_ok   = ({1'b0, i_cfg_ch} < (CH_W + 1)'(NUM_CH));
  assign w_half_ok = (i_cfg_half != '0);
  assign w_cfg_ok  = i_cfg_we && w_ch_ok && w_half_ok;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= i_cfg_we && !(w_ch_ok && w_half_ok);
    end
  end

  assign o_cfg_err = r_cfg_err;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    assign w_wr[g] = w_cfg_ok && (i_cfg_ch == CH_W'(g));

    clk_div_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_HALF(DEFAULT_HALF)
    ) u_chan (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_en     (i_en[g]),
      .i_wr     (w_wr[g]),
      .i_half   (i_cfg_half),
      .o_clk_div(o_clk_div[g]),
      .o_tick   (o_tick[g]),
      .o_pend   (o_pend[g])
    );
  end

endmodule
